// File: rtl/seg7_mmio_display.sv
// rtl/seg7_mmio_display.sv - memory-mapped 8-digit seven-segment display with two scanned digit groups
// Holds VALUE/MASK/COUNT registers behind a CPU load/store port and drives two muxed digit groups.
module seg7_mmio_display #(
   parameter logic [31:0] DISP_ADDR = 32'h0000_0054,
   parameter int          SCAN_DIV  = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] writedata,
   input  logic [31:0] dataadr,
   input  logic        memwrite,
   output logic [31:0] rdata,
   output logic        hit,
   output logic [7:0]  seg,
   output logic [7:0]  seg1,
   output logic [7:0]  an
);

   localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [31:0]   MASK_ADDR  = DISP_ADDR + 32'd4;
   localparam logic [31:0]   COUNT_ADDR = DISP_ADDR + 32'd8;

   logic [31:0]   r_value;
   logic [7:0]    r_mask;
   logic [15:0]   r_count;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;

   logic          w_wr_value;
   logic          w_wr_mask;
   logic          w_wrap;
   logic [3:0]    w_lo_nib;
   logic [3:0]    w_hi_nib;
   logic [3:0]    w_sel;
   logic          w_lo_en;
   logic          w_hi_en;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_wr_value = memwrite && (dataadr == DISP_ADDR);
   assign w_wr_mask  = memwrite && (dataadr == MASK_ADDR);
   assign w_wrap     = (r_presc == PRESC_LAST);

   // Low group shows nibble k, high group nibble k+4 of the same VALUE snapshot.
   assign w_lo_nib = r_value[{1'b0, r_idx, 2'b00} +: 4];
   assign w_hi_nib = r_value[{1'b1, r_idx, 2'b00} +: 4];
   assign w_sel    = 4'b0001 << r_idx;
   assign w_lo_en  = r_mask[{1'b0, r_idx}];
   assign w_hi_en  = r_mask[{1'b1, r_idx}];

   always_comb begin
      hit   = 1'b0;
      rdata = 32'h0;
      if (dataadr == DISP_ADDR) begin
         hit   = 1'b1;
         rdata = r_value;
      end else if (dataadr == MASK_ADDR) begin
         hit   = 1'b1;
         rdata = {24'h0, r_mask};
      end else if (dataadr == COUNT_ADDR) begin
         hit   = 1'b1;
         rdata = {16'h0, r_count};
      end
   end

   // Outputs are computed from pre-edge state so a store and a scan step land together one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= 32'h0;
         r_mask  <= 8'hFF;
         r_count <= 16'h0;
         r_presc <= '0;
         r_idx   <= 2'd0;
         seg     <= 8'h00;
         seg1    <= 8'h00;
         an      <= 8'hFF;
      end else begin
         if (w_wr_value) begin
            r_value <= writedata;
            r_count <= r_count + 16'd1;
         end
         if (w_wr_mask) begin
            r_mask <= writedata[7:0];
         end
         if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         seg  <= w_lo_en ? {1'b0, hex7(w_lo_nib)} : 8'h00;
         seg1 <= w_hi_en ? {1'b0, hex7(w_hi_nib)} : 8'h00;
         an   <= ~{w_sel & r_mask[7:4], w_sel & r_mask[3:0]};
      end
   end

endmodule

// File: tb/tb_seg7_mmio_display.sv
// tb/tb_seg7_mmio_display.sv - self-checking bench for seg7_mmio_display
// Directed scenarios plus random stores, checked against a cycle-count based display model.
module tb_seg7_mmio_display;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        memwrite;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic [31:0] rdata;
   logic        hit;
   logic [7:0]  seg;
   logic [7:0]  seg1;
   logic [7:0]  an;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] m_value;
   logic [7:0]  m_mask;
   int          m_count;
   int          cyc;

   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [7:0]  rot_an   [4]  = '{8'hEE, 8'hDD, 8'hBB, 8'h77};
   logic [7:0]  rot_seg  [4]  = '{8'h06, 8'h5B, 8'h4F, 8'h66};
   logic [7:0]  rot_seg1 [4]  = '{8'h6D, 8'h7D, 8'h07, 8'h7F};
   logic [31:0] rnd_addr [6]  = '{32'h54, 32'h58, 32'h5C, 32'h100, 32'h55, 32'h0};

   seg7_mmio_display #(.DISP_ADDR(32'h0000_0054), .SCAN_DIV(SD)) dut (
      .clk       (clk),
      .rst       (rst),
      .writedata (writedata),
      .dataadr   (dataadr),
      .memwrite  (memwrite),
      .rdata     (rdata),
      .hit       (hit),
      .seg       (seg),
      .seg1      (seg1),
      .an        (an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_value = 32'h0;
      m_mask  = 8'hFF;
      m_count = 0;
      cyc     = 0;
   endtask

   function automatic logic [7:0] exp_digit(input int d);
      logic [3:0] n;
      n = m_value[4*d +: 4];
      return m_mask[d] ? {1'b0, hex_tab[n]} : 8'h00;
   endfunction

   // One clock: predict outputs from pre-edge model state, apply the store, then compare.
   task automatic tick();
      logic [7:0] e_seg, e_seg1, e_an;
      int k;
      if (rst) begin
         e_seg = 8'h00; e_seg1 = 8'h00; e_an = 8'hFF;
         m_reset();
      end else begin
         k      = (cyc / SD) % 4;
         e_seg  = exp_digit(k);
         e_seg1 = exp_digit(k + 4);
         e_an   = 8'hFF;
         if (m_mask[k])     e_an[k]     = 1'b0;
         if (m_mask[k + 4]) e_an[k + 4] = 1'b0;
         if (memwrite && dataadr == 32'h54) begin
            m_value = writedata;
            m_count = (m_count + 1) % 65536;
         end
         if (memwrite && dataadr == 32'h58) m_mask = writedata[7:0];
         cyc++;
      end
      @(posedge clk);
      #1;
      chk("seg", {24'h0, seg}, {24'h0, e_seg});
      chk("seg1", {24'h0, seg1}, {24'h0, e_seg1});
      chk("an", {24'h0, an}, {24'h0, e_an});
   endtask

   task automatic store_tick(input logic [31:0] addr, input logic [31:0] data);
      memwrite  = 1'b1;
      dataadr   = addr;
      writedata = data;
      tick();
      memwrite  = 1'b0;
   endtask

   task automatic rd_model(input logic [31:0] addr);
      logic [31:0] e_d;
      logic        e_h;
      e_h = 1'b1;
      case (addr)
         32'h54:  e_d = m_value;
         32'h58:  e_d = {24'h0, m_mask};
         32'h5C:  e_d = 32'(m_count);
         default: begin e_d = 32'h0; e_h = 1'b0; end
      endcase
      dataadr = addr;
      #1;
      chk("rdata_model", rdata, e_d);
      chk("hit_model", {31'h0, hit}, {31'h0, e_h});
   endtask

   task automatic rd_const(input string tag, input logic [31:0] addr, input logic [31:0] e_d,
                           input logic e_h);
      dataadr = addr;
      #1;
      chk(tag, rdata, e_d);
      chk({tag, "_hit"}, {31'h0, hit}, {31'h0, e_h});
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      chk("rst_seg", {24'h0, seg}, 32'h00);
      chk("rst_seg1", {24'h0, seg1}, 32'h00);
      chk("rst_an", {24'h0, an}, 32'hFF);
      m_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      memwrite  = 1'b0;
      dataadr   = 32'h0;
      writedata = 32'h0;
      m_reset();
      #12;
      chk("por_seg", {24'h0, seg}, 32'h00);
      chk("por_an", {24'h0, an}, 32'hFF);
      rst = 1'b0;
      tick();
      chk("first_an", {24'h0, an}, 32'hEE);
      chk("first_seg", {24'h0, seg}, 32'h3F);

      // Asynchronous reset pulse between edges
      repeat (3) tick();
      rst_pulse();
      tick();
      chk("rel_an", {24'h0, an}, 32'hEE);
      chk("rel_seg1", {24'h0, seg1}, 32'h3F);

      // Store and full rotation
      rst_pulse();
      store_tick(32'h54, 32'h8765_4321);
      for (int t = 2; t <= 16; t++) begin
         tick();
         if (t % 4 == 0) begin
            chk("rot_an", {24'h0, an}, {24'h0, rot_an[t/4 - 1]});
            chk("rot_seg", {24'h0, seg}, {24'h0, rot_seg[t/4 - 1]});
            chk("rot_seg1", {24'h0, seg1}, {24'h0, rot_seg1[t/4 - 1]});
         end
      end
      rd_const("count1", 32'h5C, 32'h1, 1'b1);

      // High group masked off
      store_tick(32'h58, 32'h0000_000F);
      rd_const("mask_rd", 32'h58, 32'h0000_000F, 1'b1);
      repeat (16) begin
         tick();
         chk("mask_an_hi", {28'h0, an[7:4]}, 32'hF);
         chk("mask_seg1", {24'h0, seg1}, 32'h00);
      end

      // COUNT wrap and ignored stores
      rst_pulse();
      memwrite = 1'b1;
      dataadr  = 32'h54;
      repeat (65535) begin
         writedata = $urandom;
         tick();
      end
      memwrite = 1'b0;
      rd_const("count_ffff", 32'h5C, 32'h0000_FFFF, 1'b1);
      store_tick(32'h54, $urandom);
      rd_const("count_wrap", 32'h5C, 32'h0000_0000, 1'b1);
      store_tick(32'h5C, $urandom);
      store_tick(32'h100, $urandom);
      store_tick(32'h55, $urandom);
      rd_model(32'h54);
      rd_model(32'h58);
      rd_model(32'h5C);
      rd_const("unmapped", 32'h100, 32'h0, 1'b0);

      // Store on the prescaler wrap edge
      rst_pulse();
      repeat (SD - 1) tick();
      store_tick(32'h54, 32'hFFFF_FFFF);
      tick();
      chk("sim_seg", {24'h0, seg}, 32'h71);
      chk("sim_seg1", {24'h0, seg1}, 32'h71);
      chk("sim_an", {24'h0, an}, 32'hDD);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rd_model(rnd_addr[$urandom_range(0, 5)]);
         memwrite  = 1'($urandom_range(0, 1));
         dataadr   = rnd_addr[$urandom_range(0, 5)];
         writedata = $urandom;
         tick();
      end
      memwrite = 1'b0;
      rd_model(32'h54);
      rd_model(32'h58);
      rd_model(32'h5C);

      // Reset at scan index 2, store held during reset is dropped
      rst_pulse();
      repeat (2 * SD + 1) tick();
      chk("mid_an", {24'h0, an}, 32'hBB);
      rst = 1'b1;
      #1;
      chk("mid_rst_seg", {24'h0, seg}, 32'h00);
      chk("mid_rst_an", {24'h0, an}, 32'hFF);
      memwrite  = 1'b1;
      dataadr   = 32'h54;
      writedata = 32'hDEAD_BEEF;
      tick();
      memwrite = 1'b0;
      rd_const("rst_store_val", 32'h54, 32'h0, 1'b1);
      rd_const("rst_store_cnt", 32'h5C, 32'h0, 1'b1);
      rd_const("rst_store_mask", 32'h58, 32'hFF, 1'b1);
      rst = 1'b0;
      m_reset();
      tick();
      chk("resume_an", {24'h0, an}, 32'hEE);
      chk("resume_seg", {24'h0, seg}, 32'h3F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
